// File: rtl/cp_s1_pkg.sv
// Shared definitions for the cp_s1 read stage.
// Contents: the read-sequencer state encoding and the derivation of the
// return-data FIFO depth from the RAM read latency.
package cp_s1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

    // Every read in flight needs a FIFO slot. Two extra slots let strobes keep
    // flowing at one per cycle while the head word waits for its handshake.
    function automatic int fifo_depth(input int rd_latency);
        return rd_latency + 32'sd2;
    endfunction

endpackage

// File: rtl/cp_s1_sync_fifo.sv
// Single-clock FIFO with a combinational head-of-queue read.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, push_data - write strobe and data (ignored when full)
//   pop             - consume the head word (ignored when empty)
//   pop_data        - current head word
//   full, empty     - occupancy flags
//   count           - number of stored words
module cp_s1_sync_fifo #(
    parameter int WIDTH = 128,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cp_s1_read_ram.sv
// Frame reader: on a start pulse, reads DATA_NUM words from a RAM with fixed
// read latency and streams them out over a valid/ready interface.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   i_start                   - frame-start pulse (honoured only when idle)
//   o_m1_rd_en, o_m1_rd_addr  - RAM read strobe and address
//   i_m1_rd_data              - RAM data, valid RD_LATENCY cycles after strobe
//   o_data, o_data_valid,
//   o_data_last, i_data_ready - downstream stream
//   o_busy, o_done            - frame in progress / frame-complete pulse
module cp_s1_read_ram
    import cp_s1_pkg::*;
#(
    parameter int READ_RAM_WIDTH = 128,
    parameter int SAMPLE_WIDTH   = 32,
    parameter int DATA_NUM       = 1024,
    parameter int INIT_ADDR      = 0,
    parameter int ADD_ADDR       = 16,
    parameter int RD_LATENCY     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    output logic                      o_m1_rd_en,
    output logic [SAMPLE_WIDTH-1:0]   o_m1_rd_addr,
    input  logic [READ_RAM_WIDTH-1:0] i_m1_rd_data,
    output logic [READ_RAM_WIDTH-1:0] o_data,
    output logic                      o_data_valid,
    output logic                      o_data_last,
    input  logic                      i_data_ready,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int FIFO_DEPTH = fifo_depth(RD_LATENCY);
    localparam int FCNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W      = FCNT_W + 2;
    localparam int WCNT_W     = $clog2(DATA_NUM) + 1;
    localparam logic [SAMPLE_WIDTH-1:0] ADDR_INIT = SAMPLE_WIDTH'(INIT_ADDR);
    localparam logic [SAMPLE_WIDTH-1:0] ADDR_STEP = SAMPLE_WIDTH'(ADD_ADDR);

    rd_state_e           state_r;
    rd_state_e           next_state_s;
    logic                rd_en_r;
    logic [SAMPLE_WIDTH-1:0] rd_addr_r;
    logic [SAMPLE_WIDTH-1:0] next_addr_r;
    logic [WCNT_W-1:0]   rd_cnt_r;
    logic [RD_LATENCY-1:0] vld_sr_r;
    logic [WCNT_W-1:0]   out_cnt_r;
    logic                busy_r;
    logic                done_r;

    logic                issue_s;
    logic                credit_s;
    logic [OUT_W-1:0]    outstanding_s;
    logic                push_s;
    logic                pop_s;
    logic                last_word_s;
    logic                last_hs_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [FCNT_W-1:0]   fifo_count_s;
    logic [READ_RAM_WIDTH-1:0] fifo_head_s;

    cp_s1_sync_fifo #(
        .WIDTH (READ_RAM_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (i_m1_rd_data),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // The oldest stage of the in-flight shift register marks the cycle the RAM word is valid.
    assign push_s       = vld_sr_r[RD_LATENCY-1];
    assign o_data_valid = ~fifo_empty_s;
    assign o_data       = fifo_head_s;
    assign pop_s        = o_data_valid & i_data_ready;
    assign last_word_s  = (out_cnt_r == WCNT_W'(DATA_NUM - 1));
    assign o_data_last  = o_data_valid & last_word_s;
    assign last_hs_s    = pop_s & last_word_s;

    assign o_m1_rd_en   = rd_en_r;
    assign o_m1_rd_addr = rd_addr_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;

    // Credit check: the strobe on the bus now, reads still in the RAM pipe and
    // stored words all claim a FIFO slot; a word leaving this cycle frees one.
    always_comb begin
        outstanding_s = OUT_W'(rd_en_r);
        for (int i = 0; i < RD_LATENCY; i++) begin
            outstanding_s = outstanding_s + OUT_W'(vld_sr_r[i]);
        end
        outstanding_s = outstanding_s + OUT_W'(fifo_count_s);
        if (pop_s) begin
            outstanding_s = outstanding_s - OUT_W'(1);
        end else begin
            outstanding_s = outstanding_s;
        end
        credit_s = (outstanding_s < OUT_W'(FIFO_DEPTH)) && !(fifo_full_s && !pop_s);
    end

    // Next-state and strobe decision; a start pulse issues the first read directly.
    always_comb begin
        next_state_s = state_r;
        issue_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    next_state_s = ST_READ;
                    issue_s      = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (credit_s) begin
                    issue_s = 1'b1;
                    if (rd_cnt_r == WCNT_W'(DATA_NUM - 1)) begin
                        next_state_s = ST_DRAIN;
                    end else begin
                        next_state_s = ST_READ;
                    end
                end else begin
                    next_state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (last_hs_s) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State register, read strobe, address generation and read counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rd_en_r     <= 1'b0;
            rd_addr_r   <= ADDR_INIT;
            next_addr_r <= ADDR_INIT;
            rd_cnt_r    <= {WCNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            rd_en_r <= issue_s;
            if (issue_s) begin
                if (state_r == ST_IDLE) begin
                    rd_addr_r   <= ADDR_INIT;
                    next_addr_r <= ADDR_INIT + ADDR_STEP;
                    rd_cnt_r    <= WCNT_W'(1);
                end else begin
                    rd_addr_r   <= next_addr_r;
                    next_addr_r <= next_addr_r + ADDR_STEP;
                    rd_cnt_r    <= rd_cnt_r + WCNT_W'(1);
                end
            end
        end
    end

    // In-flight shift register: one bit per cycle of RAM latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr_r <= {RD_LATENCY{1'b0}};
        end else begin
            vld_sr_r[0] <= rd_en_r;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr_r[i] <= vld_sr_r[i-1];
            end
        end
    end

    // Output word counter, busy flag and frame-complete pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_cnt_r <= {WCNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            if (state_r == ST_IDLE) begin
                out_cnt_r <= {WCNT_W{1'b0}};
            end else if (pop_s) begin
                out_cnt_r <= out_cnt_r + WCNT_W'(1);
            end
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= last_hs_s;
        end
    end

endmodule

// File: tb/tb_cp_s1_read_ram.sv
// Bench for cp_s1_read_ram: three instances (latency 2 / 1 / 4) each backed by
// a latency-accurate RAM model; observed frames are compared with the word
// sequence expected from the address rule INIT + k*ADD.
module tb_cp_s1_read_ram;

    localparam int NDUT = 3;
    localparam int DN   = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_a   [NDUT];
    logic         ready_a   [NDUT];
    logic         rd_en_a   [NDUT];
    logic [31:0]  addr_a    [NDUT];
    logic [127:0] rd_data_a [NDUT];
    logic [127:0] data_a    [NDUT];
    logic         valid_a   [NDUT];
    logic         last_a    [NDUT];
    logic         busy_a    [NDUT];
    logic         done_a    [NDUT];

    int checks = 0;
    int errors = 0;

    logic [31:0]  obs_addr [$];
    int           obs_scyc [$];
    logic [127:0] obs_word [$];
    int           obs_hcyc [$];
    bit           obs_last [$];
    int           obs_done [$];
    int max_out, stall_viol, busy_viol, timeout_flag, post_strobes;

    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        case (d)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] init_of(input int d);
        return (d == 0) ? 32'd0 : 32'd32;
    endfunction

    function automatic logic [31:0] add_of(input int d);
        return (d == 0) ? 32'd16 : 32'd4;
    endfunction

    function automatic logic [127:0] ram_f(input logic [31:0] a);
        return {a ^ 32'hDEAD_BEEF, a * 32'd3 + 32'd7, ~a, a};
    endfunction

    function automatic logic [31:0] exp_addr(input int d, input int k);
        return init_of(d) + 32'(k) * add_of(d);
    endfunction

    cp_s1_read_ram #(.READ_RAM_WIDTH(128), .SAMPLE_WIDTH(32), .DATA_NUM(DN),
                     .INIT_ADDR(0), .ADD_ADDR(16), .RD_LATENCY(2)) u_dut0 (
        .clk(clk), .rst(rst), .i_start(start_a[0]), .o_m1_rd_en(rd_en_a[0]),
        .o_m1_rd_addr(addr_a[0]), .i_m1_rd_data(rd_data_a[0]), .o_data(data_a[0]),
        .o_data_valid(valid_a[0]), .o_data_last(last_a[0]), .i_data_ready(ready_a[0]),
        .o_busy(busy_a[0]), .o_done(done_a[0]));

    cp_s1_read_ram #(.READ_RAM_WIDTH(128), .SAMPLE_WIDTH(32), .DATA_NUM(DN),
                     .INIT_ADDR(32), .ADD_ADDR(4), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(start_a[1]), .o_m1_rd_en(rd_en_a[1]),
        .o_m1_rd_addr(addr_a[1]), .i_m1_rd_data(rd_data_a[1]), .o_data(data_a[1]),
        .o_data_valid(valid_a[1]), .o_data_last(last_a[1]), .i_data_ready(ready_a[1]),
        .o_busy(busy_a[1]), .o_done(done_a[1]));

    cp_s1_read_ram #(.READ_RAM_WIDTH(128), .SAMPLE_WIDTH(32), .DATA_NUM(DN),
                     .INIT_ADDR(32), .ADD_ADDR(4), .RD_LATENCY(4)) u_dut2 (
        .clk(clk), .rst(rst), .i_start(start_a[2]), .o_m1_rd_en(rd_en_a[2]),
        .o_m1_rd_addr(addr_a[2]), .i_m1_rd_data(rd_data_a[2]), .o_data(data_a[2]),
        .o_data_valid(valid_a[2]), .o_data_last(last_a[2]), .i_data_ready(ready_a[2]),
        .o_busy(busy_a[2]), .o_done(done_a[2]));

    // RAM models: word returned exactly L cycles after its strobe, random junk otherwise.
    for (genvar g = 0; g < NDUT; g++) begin : g_ram
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
        logic         pen   [4];
        logic [31:0]  paddr [4];
        logic [127:0] junk;
        always @(posedge clk) begin
            pen[0]   <= rd_en_a[g];
            paddr[0] <= addr_a[g];
            for (int i = 1; i < 4; i++) begin
                pen[i]   <= pen[i-1];
                paddr[i] <= paddr[i-1];
            end
            junk <= {$urandom, $urandom, $urandom, $urandom};
        end
        assign rd_data_a[g] = pen[L-1] ? ram_f(paddr[L-1]) : junk;
    end

    // Drives one frame on DUT d and records what it observes; no judgement here.
    // rmode: 0 ready high, 1 toggle then 20-cycle stall, 2 random.
    task automatic run_frame(input int d, input int rmode, input int restart_cyc,
                             input bit start_on_last, input int stop_after);
        int issued, accepted, vidx, post;
        bit v, lst, r, prev_stall, prev_lst, finished, last_hs_seen, vstarted;
        logic [127:0] dat, prev_dat;
        obs_addr.delete(); obs_scyc.delete(); obs_word.delete();
        obs_hcyc.delete(); obs_last.delete(); obs_done.delete();
        max_out = 0; stall_viol = 0; busy_viol = 0; post_strobes = 0; timeout_flag = 1;
        issued = 0; accepted = 0; vidx = 0; post = 0; prev_stall = 0; prev_lst = 0;
        finished = 0; last_hs_seen = 0; vstarted = 0; prev_dat = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            v = valid_a[d]; dat = data_a[d]; lst = last_a[d];
            if (rd_en_a[d]) begin
                obs_addr.push_back(addr_a[d]);
                obs_scyc.push_back(cyc);
                issued++;
                if (finished) post_strobes++;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (prev_stall && (!v || dat !== prev_dat || lst !== prev_lst)) stall_viol++;
            if (cyc >= 1 && !last_hs_seen && busy_a[d] !== 1'b1) busy_viol++;
            if (finished && busy_a[d] !== 1'b0) busy_viol++;
            if (done_a[d]) begin
                obs_done.push_back(cyc);
                finished = 1;
            end
            if (finished) post++;
            if (post > 6) begin
                timeout_flag = 0;
                start_a[d] = 1'b0;
                break;
            end
            if (v) vstarted = 1;
            case (rmode)
                0: r = 1;
                1: begin
                    if (!vstarted)      r = 1;
                    else if (vidx < 4)  r = (vidx % 2 == 0);
                    else if (vidx < 24) r = 0;
                    else                r = 1;
                end
                default: r = ($urandom_range(0, 2) != 0);
            endcase
            if (vstarted) vidx++;
            ready_a[d] = r;
            start_a[d] = (cyc == 0) || (cyc == restart_cyc) || (start_on_last && v && lst && r);
            if (v && r) begin
                obs_word.push_back(dat);
                obs_last.push_back(lst);
                obs_hcyc.push_back(cyc);
                accepted++;
                if (lst) last_hs_seen = 1;
            end
            prev_stall = v && !r; prev_dat = dat; prev_lst = lst;
            if (stop_after > 0 && accepted >= stop_after) begin
                timeout_flag = 0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            start_a[d] = 1'b0;
            ready_a[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            checks++;
            if (rd_en_a[d] !== 1'b0 || valid_a[d] !== 1'b0 || last_a[d] !== 1'b0 ||
                busy_a[d] !== 1'b0 || done_a[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d got en=%b v=%b l=%b b=%b d=%b expected all 0",
                         d, rd_en_a[d], valid_a[d], last_a[d], busy_a[d], done_a[d]);
            end
            checks++;
            if (addr_a[d] !== init_of(d)) begin
                errors++;
                $display("FAIL reset_addr dut%0d got %h expected %h", d, addr_a[d], init_of(d));
            end
            checks++;
            if (data_a[d] !== 128'd0) begin
                errors++;
                $display("FAIL reset_data dut%0d got %h expected 0", d, data_a[d]);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rd_en_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got en=%b busy=%b expected 0 0", rd_en_a[0], busy_a[0]);
        end
    endtask

    task automatic test_basic();
        run_frame(0, 0, -1, 1'b0, 0);
        checks++;
        if (timeout_flag != 0) begin errors++; $display("FAIL basic_timeout got 1 expected 0"); end
        checks++;
        if (obs_addr.size() != DN) begin
            errors++; $display("FAIL basic_strobes got %0d expected %0d", obs_addr.size(), DN);
        end
        for (int j = 0; j < DN && j < obs_addr.size(); j++) begin
            checks++;
            if (obs_addr[j] !== exp_addr(0, j) || obs_scyc[j] != j + 1) begin
                errors++;
                $display("FAIL basic_strobe[%0d] got addr %h cyc %0d expected addr %h cyc %0d",
                         j, obs_addr[j], obs_scyc[j], exp_addr(0, j), j + 1);
            end
        end
        checks++;
        if (obs_word.size() != DN) begin
            errors++; $display("FAIL basic_words got %0d expected %0d", obs_word.size(), DN);
        end
        for (int j = 0; j < DN && j < obs_word.size(); j++) begin
            checks++;
            if (obs_word[j] !== ram_f(exp_addr(0, j)) || obs_last[j] !== (j == DN - 1)) begin
                errors++;
                $display("FAIL basic_word[%0d] got %h last %b expected %h last %b", j,
                         obs_word[j], obs_last[j], ram_f(exp_addr(0, j)), (j == DN - 1));
            end
        end
        checks++;
        if (obs_done.size() != 1 || obs_hcyc.size() != DN || obs_done[0] != obs_hcyc[DN-1] + 1) begin
            errors++;
            $display("FAIL basic_done got %0d pulses expected 1 pulse one cycle after last", obs_done.size());
        end
        checks++;
        if (obs_hcyc.size() == 0 || obs_scyc.size() == 0 || obs_hcyc[0] - obs_scyc[0] < lat_of(0) + 1) begin
            errors++; $display("FAIL basic_first_valid got early or missing expected >= %0d cycles", lat_of(0) + 1);
        end
        checks++;
        if (busy_viol != 0 || max_out > lat_of(0) + 2) begin
            errors++; $display("FAIL basic_busy_out got busy_viol %0d max_out %0d expected 0 <=%0d",
                               busy_viol, max_out, lat_of(0) + 2);
        end
    endtask

    task automatic test_backpressure();
        run_frame(0, 1, -1, 1'b0, 0);
        checks++;
        if (timeout_flag != 0) begin errors++; $display("FAIL bp_timeout got 1 expected 0"); end
        checks++;
        if (max_out > lat_of(0) + 2) begin
            errors++; $display("FAIL bp_outstanding got %0d expected <= %0d", max_out, lat_of(0) + 2);
        end
        checks++;
        if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes expected 0", stall_viol); end
        checks++;
        if (obs_word.size() != DN || obs_addr.size() != DN) begin
            errors++; $display("FAIL bp_count got %0d words %0d strobes expected %0d",
                               obs_word.size(), obs_addr.size(), DN);
        end
        for (int j = 0; j < DN && j < obs_word.size(); j++) begin
            checks++;
            if (obs_word[j] !== ram_f(exp_addr(0, j)) || obs_last[j] !== (j == DN - 1)) begin
                errors++;
                $display("FAIL bp_word[%0d] got %h last %b expected %h", j, obs_word[j], obs_last[j],
                         ram_f(exp_addr(0, j)));
            end
        end
        checks++;
        if (obs_done.size() != 1) begin errors++; $display("FAIL bp_done got %0d expected 1", obs_done.size()); end
    endtask

    task automatic test_restart();
        run_frame(0, 2, 3, 1'b1, 0);
        checks++;
        if (timeout_flag != 0) begin errors++; $display("FAIL restart_timeout got 1 expected 0"); end
        checks++;
        if (obs_addr.size() != DN || post_strobes != 0) begin
            errors++; $display("FAIL restart_strobes got %0d post %0d expected %0d 0",
                               obs_addr.size(), post_strobes, DN);
        end
        checks++;
        if (obs_word.size() != DN) begin
            errors++; $display("FAIL restart_words got %0d expected %0d", obs_word.size(), DN);
        end
        for (int j = 0; j < DN && j < obs_word.size(); j++) begin
            checks++;
            if (obs_word[j] !== ram_f(exp_addr(0, j))) begin
                errors++;
                $display("FAIL restart_word[%0d] got %h expected %h", j, obs_word[j], ram_f(exp_addr(0, j)));
            end
        end
        checks++;
        if (obs_done.size() != 1 || busy_viol != 0 || stall_viol != 0) begin
            errors++; $display("FAIL restart_done got done %0d busy_viol %0d stall %0d expected 1 0 0",
                               obs_done.size(), busy_viol, stall_viol);
        end
    endtask

    task automatic test_reset_midframe();
        int quiet;
        run_frame(0, 0, -1, 1'b0, 3);
        checks++;
        if (obs_word.size() != 3 || obs_word[0] !== ram_f(exp_addr(0, 0))) begin
            errors++; $display("FAIL midrst_pre got %0d words expected 3 starting at addr 0", obs_word.size());
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (rd_en_a[0] !== 1'b0 || valid_a[0] !== 1'b0 || last_a[0] !== 1'b0 ||
            busy_a[0] !== 1'b0 || done_a[0] !== 1'b0 || addr_a[0] !== 32'd0 || data_a[0] !== 128'd0) begin
            errors++;
            $display("FAIL midrst_outputs got en=%b v=%b b=%b addr=%h data=%h expected reset values",
                     rd_en_a[0], valid_a[0], busy_a[0], addr_a[0], data_a[0]);
        end
        @(negedge clk);
        @(negedge clk);
        start_a[0] = 1'b0;
        ready_a[0] = 1'b1;
        rst = 1'b0;
        quiet = 0;
        repeat (6) begin
            @(negedge clk);
            if (rd_en_a[0] || valid_a[0] || busy_a[0]) quiet++;
        end
        checks++;
        if (quiet != 0) begin errors++; $display("FAIL midrst_quiet got %0d active cycles expected 0", quiet); end
        run_frame(0, 2, -1, 1'b0, 0);
        checks++;
        if (timeout_flag != 0 || obs_word.size() != DN || obs_done.size() != 1) begin
            errors++; $display("FAIL midrst_frame got %0d words %0d done expected %0d 1",
                               obs_word.size(), obs_done.size(), DN);
        end
        for (int j = 0; j < DN && j < obs_word.size() && j < obs_addr.size(); j++) begin
            checks++;
            if (obs_addr[j] !== exp_addr(0, j) || obs_word[j] !== ram_f(exp_addr(0, j)) ||
                obs_last[j] !== (j == DN - 1)) begin
                errors++;
                $display("FAIL midrst_word[%0d] got addr %h data %h expected addr %h data %h", j,
                         obs_addr[j], obs_word[j], exp_addr(0, j), ram_f(exp_addr(0, j)));
            end
        end
    endtask

    task automatic test_latency();
        for (int d = 1; d < NDUT; d++) begin
            for (int m = 0; m < 3; m += 2) begin
                run_frame(d, m, -1, 1'b0, 0);
                checks++;
                if (timeout_flag != 0 || obs_addr.size() != DN || obs_word.size() != DN) begin
                    errors++; $display("FAIL lat%0d_m%0d_count got %0d strobes %0d words expected %0d",
                                       lat_of(d), m, obs_addr.size(), obs_word.size(), DN);
                end
                for (int j = 0; j < DN && j < obs_addr.size() && j < obs_word.size(); j++) begin
                    checks++;
                    if (obs_addr[j] !== exp_addr(d, j) || obs_word[j] !== ram_f(exp_addr(d, j)) ||
                        obs_last[j] !== (j == DN - 1)) begin
                        errors++;
                        $display("FAIL lat%0d_m%0d_word[%0d] got addr %h data %h expected addr %h data %h",
                                 lat_of(d), m, j, obs_addr[j], obs_word[j], exp_addr(d, j), ram_f(exp_addr(d, j)));
                    end
                    if (m == 0) begin
                        checks++;
                        if (obs_scyc[j] != j + 1) begin
                            errors++;
                            $display("FAIL lat%0d_throughput[%0d] got cyc %0d expected %0d",
                                     lat_of(d), j, obs_scyc[j], j + 1);
                        end
                    end
                end
                checks++;
                if (obs_done.size() != 1 || obs_hcyc.size() != DN || obs_done[0] != obs_hcyc[DN-1] + 1) begin
                    errors++; $display("FAIL lat%0d_m%0d_done got %0d pulses expected 1 after last",
                                       lat_of(d), m, obs_done.size());
                end
                checks++;
                if (max_out > lat_of(d) + 2 || stall_viol != 0 ||
                    obs_hcyc.size() == 0 || obs_hcyc[0] - obs_scyc[0] < lat_of(d) + 1) begin
                    errors++; $display("FAIL lat%0d_m%0d_flow got max_out %0d stall %0d expected <=%0d 0",
                                       lat_of(d), m, max_out, stall_viol, lat_of(d) + 2);
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got no finish expected completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_restart();
        test_reset_midframe();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
